// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline sequencer.
// Holds the FSM state enum, the stage write-enable bundle and the field widths.
package pipe_ctrl_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned WAIT_W = 8;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StHalt
    } state_e;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    localparam stage_en_t EnAll  = 5'b11111;
    localparam stage_en_t EnNone = 5'b00000;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard, branch and data-memory handshake bundle between the datapath and the sequencer.
// The master is the datapath/memory side; the slave is pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              ex_mem2r;
    logic              ex_regw;
    logic [REG_AW-1:0] ex_rd;
    logic              branch_taken;
    logic              mem_req;
    logic              dm_ack;
    logic              dm_req;
    logic              pc_wr;
    logic              if_id_wr;
    logic              id_ex_wr;
    logic              ex_mem_wr;
    logic              mem_wb_wr;
    logic              if_id_flush;
    logic              id_ex_flush;
    logic              dm_timeout;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem2r, ex_regw, ex_rd,
        output branch_taken, mem_req, dm_ack,
        input  dm_req, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
        input  if_id_flush, id_ex_flush, dm_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem2r, ex_regw, ex_rd,
        input  branch_taken, mem_req, dm_ack,
        output dm_req, pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
        output if_id_flush, id_ex_flush, dm_timeout, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
// Writes to r0 never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem2r,
    input  logic              ex_regw,
    input  logic [REG_AW-1:0] ex_rd,
    output logic              lu
);

    logic rs_match;
    logic rt_match;

    always_comb begin
        rs_match = (ex_rd == id_rs);
        rt_match = id_uses_rt && (ex_rd == id_rt);
        lu       = ex_mem2r && ex_regw && (ex_rd != '0) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage enables, bubbles and flushes from load-use, taken branches
// and the data-memory handshake, plus stall/flush statistics and a memory-timeout fault.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              dm_timeout_q, dm_timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic      lu;
    stage_en_t en;
    logic      if_id_flush;
    logic      id_ex_flush;
    logic      dm_req;
    logic      flush_evt;

    hazard_detect u_hazard_detect (
        .id_rs      (bus.id_rs),
        .id_rt      (bus.id_rt),
        .id_uses_rt (bus.id_uses_rt),
        .ex_mem2r   (bus.ex_mem2r),
        .ex_regw    (bus.ex_regw),
        .ex_rd      (bus.ex_rd),
        .lu         (lu)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StRun;
            wait_cnt_q   <= '0;
            dm_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            dm_timeout_q <= dm_timeout_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        dm_timeout_d = dm_timeout_q;
        case (state_q)
            StRun: begin
                if (bus.mem_req && !bus.dm_ack) begin
                    state_d    = StMemWait;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            StMemWait: begin
                if (bus.dm_ack) begin
                    state_d = StRun;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                    state_d      = StHalt;
                    dm_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // Branch/load-use resolution is shared by RUN and the ack cycle of MEM_WAIT.
    always_comb begin
        en          = EnNone;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        dm_req      = 1'b0;
        flush_evt   = 1'b0;
        case (state_q)
            StRun, StMemWait: begin
                dm_req = (state_q == StMemWait) ? 1'b1 : bus.mem_req;
                if (bus.dm_ack || (state_q == StRun && !bus.mem_req)) begin
                    en = EnAll;
                    if (bus.branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                        flush_evt   = 1'b1;
                    end else if (lu) begin
                        en.pc       = 1'b0;
                        en.if_id    = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
            end
            default: begin
                en = EnNone;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!en.pc && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_evt && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs are forced low while rst is held, independent of the register state.
    always_comb begin
        bus.pc_wr       = en.pc && !rst;
        bus.if_id_wr    = en.if_id && !rst;
        bus.id_ex_wr    = en.id_ex && !rst;
        bus.ex_mem_wr   = en.ex_mem && !rst;
        bus.mem_wb_wr   = en.mem_wb && !rst;
        bus.if_id_flush = if_id_flush && !rst;
        bus.id_ex_flush = id_ex_flush && !rst;
        bus.dm_req      = dm_req && !rst;
        bus.dm_timeout  = dm_timeout_q;
        bus.stall_cnt   = stall_cnt_q;
        bus.flush_cnt   = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with TIMEOUT=4: load-use, r0/rt filtering, branch,
// multi-cycle memory wait, timeout to HALT and asynchronous reset mid-wait.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    int   exp_stall;
    int   exp_flush;

    pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();

    pipe_hazard_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ens();
        return {bus.pc_wr, bus.if_id_wr, bus.id_ex_wr, bus.ex_mem_wr, bus.mem_wb_wr};
    endfunction

    function automatic logic [1:0] fls();
        return {bus.if_id_flush, bus.id_ex_flush};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.id_rs        = '0;
        bus.id_rt        = '0;
        bus.id_uses_rt   = 1'b0;
        bus.ex_mem2r     = 1'b0;
        bus.ex_regw      = 1'b0;
        bus.ex_rd        = '0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.dm_ack       = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        exp_stall = 0;
        exp_flush = 0;
        clear_inputs();
        rst = 1'b1;
        bus.mem_req = 1'b1;
        #3;
        check_eq("rst_en", 32'(ens()), 32'h00);
        check_eq("rst_flush", 32'(fls()), 32'h0);
        check_eq("rst_dm_req", 32'(bus.dm_req), 32'h0);
        check_eq("rst_cnts", {bus.stall_cnt, bus.flush_cnt}, 32'h0);
        check_eq("rst_timeout", 32'(bus.dm_timeout), 32'h0);
        bus.mem_req = 1'b0;
        tick();
        rst = 1'b0;

        // Load-use: one bubble, then the load has moved on to MEM.
        bus.ex_mem2r = 1'b1; bus.ex_regw = 1'b1; bus.ex_rd = 5'd5; bus.id_rs = 5'd5;
        #4;
        check_eq("lu_en", 32'(ens()), 32'b00111);
        check_eq("lu_flush", 32'(fls()), 32'b01);
        tick(); exp_stall++;
        clear_inputs();
        #4;
        check_eq("lu_next_en", 32'(ens()), 32'b11111);
        check_eq("lu_next_flush", 32'(fls()), 32'b00);
        check_eq("lu_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        tick();

        // r0 destination never stalls.
        bus.ex_mem2r = 1'b1; bus.ex_regw = 1'b1; bus.ex_rd = 5'd0; bus.id_rs = 5'd0;
        #4;
        check_eq("r0_en", 32'(ens()), 32'b11111);
        tick();

        // rt match only counts when the ID instruction reads rt.
        bus.ex_rd = 5'd7; bus.id_rt = 5'd7; bus.id_rs = 5'd3; bus.id_uses_rt = 1'b0;
        #4;
        check_eq("rt_unused_en", 32'(ens()), 32'b11111);
        tick();
        bus.id_uses_rt = 1'b1;
        #4;
        check_eq("rt_used_en", 32'(ens()), 32'b00111);
        check_eq("rt_used_flush", 32'(fls()), 32'b01);
        tick(); exp_stall++;

        // Branch outranks the load-use still presented on the inputs.
        bus.branch_taken = 1'b1;
        #4;
        check_eq("br_en", 32'(ens()), 32'b11111);
        check_eq("br_flush", 32'(fls()), 32'b11);
        tick(); exp_flush++;
        check_eq("br_flush_cnt", 32'(bus.flush_cnt), 32'(exp_flush));
        clear_inputs();

        // Memory wait: ack three cycles after the request; a branch is applied on release.
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            check_eq("mw_en", 32'(ens()), 32'b00000);
            check_eq("mw_dm_req", 32'(bus.dm_req), 32'h1);
            check_eq("mw_flush", 32'(fls()), 32'b00);
            tick(); exp_stall++;
        end
        bus.dm_ack = 1'b1; bus.branch_taken = 1'b1;
        #4;
        check_eq("mw_ack_en", 32'(ens()), 32'b11111);
        check_eq("mw_ack_flush", 32'(fls()), 32'b11);
        check_eq("mw_ack_dm_req", 32'(bus.dm_req), 32'h1);
        tick(); exp_flush++;
        clear_inputs();
        #4;
        check_eq("mw_back_run", {27'b0, ens()} | (32'(bus.dm_req) << 8), 32'h1f);
        check_eq("mw_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        check_eq("mw_flush_cnt", 32'(bus.flush_cnt), 32'(exp_flush));
        tick();

        // Timeout: RUN stall cycle plus four MEM_WAIT cycles, then HALT.
        bus.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #4;
            check_eq("to_wait_en", 32'(ens()), 32'b00000);
            check_eq("to_wait_flag", 32'(bus.dm_timeout), 32'h0);
            tick(); exp_stall++;
        end
        check_eq("to_flag", 32'(bus.dm_timeout), 32'h1);
        bus.dm_ack = 1'b1; bus.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            check_eq("halt_en", 32'(ens()), 32'b00000);
            check_eq("halt_flush", 32'(fls()), 32'b00);
            check_eq("halt_dm_req", 32'(bus.dm_req), 32'h0);
            tick(); exp_stall++;
        end
        check_eq("halt_stall_cnt", 32'(bus.stall_cnt), 32'(exp_stall));
        check_eq("halt_flush_cnt", 32'(bus.flush_cnt), 32'(exp_flush));
        check_eq("halt_flag", 32'(bus.dm_timeout), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("halt_rst_flag", 32'(bus.dm_timeout), 32'h0);
        check_eq("halt_rst_cnt", 32'(bus.stall_cnt), 32'h0);
        tick();
        clear_inputs();
        rst = 1'b0;

        // Reset after two MEM_WAIT cycles, then a single-cycle access.
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("mwrst_en", 32'(ens()), 32'b00000);
        check_eq("mwrst_cnt", 32'(bus.stall_cnt), 32'h0);
        tick();
        rst = 1'b0;
        bus.dm_ack = 1'b1;
        #4;
        check_eq("sc_en", 32'(ens()), 32'b11111);
        check_eq("sc_dm_req", 32'(bus.dm_req), 32'h1);
        tick();
        clear_inputs();
        #4;
        check_eq("sc_run_dm_req", 32'(bus.dm_req), 32'h0);
        check_eq("sc_cnts", {bus.stall_cnt, bus.flush_cnt}, 32'h0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the 5-stage core. Generates the write enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Three sources drive it:
- load-use hazards;
- taken branches resolved in EX;
- a data-memory request/acknowledge handshake that may take multiple cycles.

It also reports stall statistics and a memory-timeout fault.

## Interface
Parameters:
- TIMEOUT, 255: max MEM_WAIT cycles before fault; legal range 1..255.
- CNT_W, 16: width of stall/flush counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- ex_mem2r  in  1  EX instruction is a load (MEM2R).
- ex_regw  in  1  EX instruction writes a register.
- ex_rd  in  5  EX destination register.
- branch_taken  in  1  EX resolved a taken branch/jump.
- mem_req  in  1  MEM instruction accesses data memory.
- dm_ack  in  1  data memory completes the access this cycle.
- dm_req  out  1  request to data memory.
- pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr  out  1 each  stage-register write enables (MEM_WB_WR etc.).
- if_id_flush, id_ex_flush  out  1 each  load a bubble (all control fields zero) on the next edge.
- dm_timeout  out  1  sticky fault flag.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_wr=0.
- flush_cnt  out  CNT_W  saturating count of taken-branch flushes.

## Operation
FSM states are RUN, MEM_WAIT and HALT. Reset state is RUN.

While rst is high:
- all write enables, flushes and dm_req are 0;
- dm_timeout=0, stall_cnt=0, flush_cnt=0, wait counter=0.

Hazard term:
- lu = ex_mem2r & ex_regw & (ex_rd≠0) & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).

RUN, decisions in priority order:
1. mem_req & !dm_ack (memory stall):
   - all five write enables = 0, flushes = 0;
   - next state MEM_WAIT; wait counter loads 1.
2. branch_taken:
   - all enables = 1, if_id_flush = 1, id_ex_flush = 1; lu is ignored.
   - flush_cnt increments.
3. lu:
   - pc_wr = 0, if_id_wr = 0, id_ex_flush = 1;
   - id_ex_wr, ex_mem_wr and mem_wb_wr stay 1.
4. Otherwise all enables = 1 and flushes = 0.

MEM_WAIT:
- dm_req = 1.
- If dm_ack:
  - all enables = 1;
  - branch_taken and lu are evaluated exactly as in RUN items 2–3 in this same cycle;
  - next state RUN.
- Else:
  - all enables = 0;
  - the wait counter increments;
  - when the counter equals TIMEOUT and dm_ack is still low, set dm_timeout and go to HALT.

HALT:
- All enables, flushes and dm_req = 0 until rst. dm_timeout stays 1.

dm_req = mem_req in RUN; 1 in MEM_WAIT; 0 in HALT.

The memory stall outranks both flush and load-use. A branch or hazard pending during MEM_WAIT stays valid because ID/EX and EX/MEM are frozen, so it is applied on release.

Counters saturate at all-ones; they never wrap. stall_cnt increments in every cycle with pc_wr=0, including HALT.

## Timing
- All control outputs are combinational from state and inputs, valid in the same cycle.
- State, counters and dm_timeout are registered.
- Load-use costs exactly 1 bubble cycle:
  - in the next cycle the load is in MEM and EX holds the bubble, so lu deasserts.
- Single-cycle memory (dm_ack together with dm_req) costs 0 cycles.
- Each extra cycle before dm_ack costs 1 full-pipeline freeze cycle.
- Timeout is detected at the edge following the TIMEOUT-th MEM_WAIT cycle without ack; HALT is entered at that edge.
- dm_ack while in HALT or when dm_req=0 is ignored.
- Asserting rst mid-wait clears everything asynchronously. After release, the block starts in RUN.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum (RUN, MEM_WAIT, HALT);
  - the stage-enable bundle type {pc, if_id, id_ex, ex_mem, mem_wb};
  - register-index width constant REG_AW=5.
- Sub-module hazard_detect (combinational): produces lu from the ID/EX fields.
- The FSM, wait counter and performance counters live in pipe_hazard_ctrl.

## Test plan
- Load-use: ex_mem2r=1, ex_regw=1, ex_rd=5, id_rs=5 → exactly one cycle with pc_wr=0, if_id_wr=0, id_ex_flush=1; the next cycle all enables are 1; stall_cnt=1.
- r0 and rt filtering:
  - ex_rd=0 with a matching id_rs → no stall;
  - ex_rd=7, id_rt=7, id_uses_rt=0 → no stall.
- Branch plus load-use in the same cycle → if_id_flush=1, id_ex_flush=1, pc_wr=1; flush_cnt=1.
- Memory wait: mem_req=1 with dm_ack arriving 3 cycles later → 3 cycles with all enables 0 and dm_req=1. In the ack cycle all enables are 1 and the state returns to RUN; stall_cnt=3.
- Timeout with TIMEOUT=4: mem_req=1 and no ack → HALT is entered and dm_timeout=1. Enables stay 0 and later acks are ignored; asserting rst clears dm_timeout to 0.
- Reset mid-MEM_WAIT (after 2 wait cycles), then a single-cycle access → 0 stall cycles and counters start from 0.
